mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_load_align.sv | 30 +++
 rtl/mem_stage.sv | 66 ++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, stall encoding,
// load opcodes and the execute-to-memory bus layout.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    MEM_LW  = 3'b000,
    MEM_LB  = 3'b001,
    MEM_LBU = 3'b010,
    MEM_LH  = 3'b011,
    MEM_LHU = 3'b100
  } mem_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [2:0]  mem_op;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en & (b.data_ram_wen == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// from a 32-bit read word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword selection ignores addr[0]; misalignment is not trapped here.
  assign w_byte = rdata[8*addr +: 8];
  assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext_data = rdata;
    case (mem_op)
      MEM_LB:  ext_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: ext_data = {24'h000000, w_byte};
      MEM_LH:  ext_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: ext_data = {16'h0000, w_half};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bus, keeps SRAM read data
// alive across downstream stalls and selects the register write-back value.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  ex_to_mem_t  r_bus;
  logic [31:0] r_hold_data;
  logic        r_hold_vld;

  logic        w_load;
  logic [31:0] w_eff_rdata;
  logic [31:0] w_ext_data;
  logic [31:0] w_rf_wdata;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5], stall[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus <= '0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
      r_bus <= '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      r_bus <= ex_to_mem_t'(ex_to_mem_bus);
    end
  end

  assign w_load = is_load(r_bus);

  // SRAM data is only valid in the load's first cycle here, so capture it
  // once while the next stage is stopped and replay it until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= 32'h0;
    end else if (stall[STALL_WB] == NO_STOP) begin
      r_hold_vld <= 1'b0;
    end else if (w_load && !r_hold_vld) begin
      r_hold_data <= data_sram_rdata;
      r_hold_vld  <= 1'b1;
    end
  end

  assign w_eff_rdata = r_hold_vld ? r_hold_data : data_sram_rdata;

  load_align u_load_align (
    .mem_op   (r_bus.mem_op),
    .addr     (r_bus.ex_result[1:0]),
    .rdata    (w_eff_rdata),
    .ext_data (w_ext_data)
  );

  assign w_rf_wdata    = r_bus.sel_rf_res ? w_ext_data : r_bus.ex_result;
  assign mem_to_id_bus = {r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};
  assign mem_to_wb_bus = {r_bus.pc, mem_to_id_bus};

endmodule
